// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision field widths, constants and FSM encoding.
package fp32_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned MANT_W   = FRAC_W + 1;
  localparam int unsigned PROD_W   = 2 * MANT_W;
  localparam int unsigned EXP_BIAS = 127;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;

endpackage

// File: rtl/fp_mant_mul_iter.sv
// Iterative shift-add significand multiplier; the start cycle already folds in the first chunk.
module fp_mant_mul_iter
  import fp32_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MANT_W-1:0] mcand,
  input  logic [MANT_W-1:0] mplier,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  localparam int unsigned N     = MANT_W / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = 5;

  logic [PROD_W-1:0] mcand_sh;
  logic [MANT_W-1:0] mplier_sh;
  logic [CNT_W-1:0]  cnt;
  logic              busy;

  // Sum of the multiplicand shifted by each set bit of one multiplier chunk.
  function automatic logic [PROD_W-1:0] partial(input logic [PROD_W-1:0]         m,
                                                input logic [BITS_PER_CYCLE-1:0] c);
    logic [PROD_W-1:0] s;
    s = '0;
    for (int unsigned j = 0; j < BITS_PER_CYCLE; j++) begin
      if (c[j]) s = s + (m << j);
    end
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      product   <= '0;
      mcand_sh  <= '0;
      mplier_sh <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      product   <= partial(PROD_W'(mcand), mplier[BITS_PER_CYCLE-1:0]);
      mcand_sh  <= PROD_W'(mcand) << BITS_PER_CYCLE;
      mplier_sh <= mplier >> BITS_PER_CYCLE;
      cnt       <= CNT_W'(1);
      busy      <= 1'b1;
      done      <= 1'b0;
    end else if (busy) begin
      product   <= product + partial(mcand_sh, mplier_sh[BITS_PER_CYCLE-1:0]);
      mcand_sh  <= mcand_sh << BITS_PER_CYCLE;
      mplier_sh <= mplier_sh >> BITS_PER_CYCLE;
      cnt       <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(N - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_multiply.sv
// Single-precision multiplier: special-case bypass, iterative significand product,
// normalise, round-to-nearest-even, flush-to-zero on underflow.
module fp_multiply
  import fp32_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);

  state_t state, state_d;

  fp32_t ua, ub;
  logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
  logic sign_c, special_c, inf_zero_c;
  logic [31:0] spec_res_c;
  logic [2:0]  spec_flags_c;

  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [PROD_W-2:0] mant_q;

  logic              mul_start, mul_done;
  logic [PROD_W-1:0] mul_prod;

  logic              rnd_inc_c;
  logic [MANT_W:0]   rnd_sum_c;
  logic signed [9:0] exp_fin_c;
  logic [FRAC_W-1:0] frac_fin_c;
  logic [31:0]       rnd_res_c;
  logic [2:0]        rnd_flags_c;

  assign ua = fp32_t'(a);
  assign ub = fp32_t'(b);

  // Operand classification; subnormals collapse to zero.
  always_comb begin
    a_nan      = (ua.exp == '1) && (ua.frac != '0);
    b_nan      = (ub.exp == '1) && (ub.frac != '0);
    a_snan     = a_nan && !ua.frac[FRAC_W-1];
    b_snan     = b_nan && !ub.frac[FRAC_W-1];
    a_inf      = (ua.exp == '1) && (ua.frac == '0);
    b_inf      = (ub.exp == '1) && (ub.frac == '0);
    a_zero     = (ua.exp == '0);
    b_zero     = (ub.exp == '0);
    sign_c     = ua.sign ^ ub.sign;
    inf_zero_c = (a_inf && b_zero) || (b_inf && a_zero);
    special_c  = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;

    spec_flags_c = 3'b000;
    if (a_nan || b_nan || inf_zero_c) begin
      spec_res_c      = QNAN;
      spec_flags_c[2] = a_snan || b_snan || inf_zero_c;
    end else if (a_inf || b_inf) begin
      spec_res_c = POS_INF | {sign_c, 31'd0};
    end else begin
      spec_res_c = {sign_c, 31'd0};
    end
  end

  assign mul_start = (state == IDLE) && in_valid && !special_c;

  fp_mant_mul_iter #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .mcand  ({1'b1, ua.frac}),
    .mplier ({1'b1, ub.frac}),
    .done   (mul_done),
    .product(mul_prod)
  );

  // Round-to-nearest-even on the normalised significand, then range check.
  always_comb begin
    rnd_inc_c  = mant_q[23] && (mant_q[22] || (|mant_q[21:0]) || mant_q[24]);
    rnd_sum_c  = (MANT_W + 1)'({1'b1, mant_q[46:24]}) + (MANT_W + 1)'(rnd_inc_c);
    exp_fin_c  = exp_q + $signed({9'd0, rnd_sum_c[MANT_W]});
    frac_fin_c = rnd_sum_c[MANT_W] ? rnd_sum_c[FRAC_W:1] : rnd_sum_c[FRAC_W-1:0];
    if (exp_fin_c >= 10'sd255) begin
      rnd_res_c   = POS_INF | {sign_q, 31'd0};
      rnd_flags_c = 3'b010;
    end else if (exp_fin_c <= 10'sd0) begin
      rnd_res_c   = {sign_q, 31'd0};
      rnd_flags_c = 3'b001;
    end else begin
      rnd_res_c   = {sign_q, exp_fin_c[EXP_W-1:0], frac_fin_c};
      rnd_flags_c = 3'b000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (in_valid) state_d = special_c ? DONE : MUL;
      MUL:     if (mul_done) state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered handshake/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      unique case (state)
        IDLE: if (in_valid) begin
          sign_q <= sign_c;
          exp_q  <= $signed(10'(ua.exp)) + $signed(10'(ub.exp)) - $signed(10'(EXP_BIAS));
          if (special_c) begin
            result <= spec_res_c;
            flags  <= spec_flags_c;
          end
        end
        NORM: begin
          exp_q  <= exp_q + (mul_prod[PROD_W-1] ? 10'sd1 : 10'sd0);
          mant_q <= mul_prod[PROD_W-1] ? mul_prod[PROD_W-2:0] : {mul_prod[PROD_W-3:0], 1'b0};
        end
        ROUND: begin
          result <= rnd_res_c;
          flags  <= rnd_flags_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp_multiply.md
FP_MULTIPLY -- requirements
Module: fp_multiply

Interface
REQ-001 Parameter BITS_PER_CYCLE, default 1, multiplier bits consumed per MUL cycle; legal values 1, 2, 4; N = 24/BITS_PER_CYCLE.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operands a, b present.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  32  IEEE-754 single-precision multiplicand.
REQ-007 b  input  32  IEEE-754 single-precision multiplier.
REQ-008 out_valid  output  1  result and flags valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 result  output  32  IEEE-754 single-precision product.
REQ-011 flags  output  3  {invalid, overflow, underflow}, valid with out_valid.

Function
REQ-012 FSM states SHALL be IDLE, MUL, NORM, ROUND, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; accept = in_valid && in_ready at an edge (cycle 0); a, b latched at accept; later input changes SHALL have no effect.
REQ-014 Normal path: IDLE -> MUL for N cycles (1..N) -> NORM (N+1) -> ROUND (N+2) -> DONE; out_valid SHALL be 1 from cycle N+3 (cycle 27 at default).
REQ-015 MUL SHALL form the 48-bit product of the 24-bit significands (hidden bit restored) by iterative shift-add, BITS_PER_CYCLE bits per cycle.
REQ-016 Sign = a[31] XOR b[31] in all cases, including zero and Inf results; canonical NaN excepted.
REQ-017 Exponent: ea + eb - 127 in 10-bit signed arithmetic; NORM: if product bit 47 set, shift right 1, exponent +1.
REQ-018 ROUND: round-to-nearest-even on guard, round, sticky (OR of all lower bits); mantissa carry-out SHALL renormalise and increment exponent.
REQ-019 Final exponent >= 255 -> signed Inf, overflow flag = 1.
REQ-020 Final exponent <= 0 -> signed zero, underflow flag = 1 (flush-to-zero output).
REQ-021 Subnormal inputs (exp 0, frac != 0) SHALL be treated as signed zero.
REQ-022 Special operands detected at accept SHALL bypass MUL/NORM/ROUND: IDLE -> DONE, out_valid from cycle 1.
REQ-023 Any NaN operand, or Inf x zero -> result 0x7FC00000; invalid flag = 1 only for Inf x zero and signalling NaN.
REQ-024 Inf x nonzero finite/Inf -> signed Inf, flags 0; zero x finite -> signed zero, flags 0.
REQ-025 DONE: result, flags and out_valid SHALL hold stable until out_valid && out_ready; then -> IDLE next cycle; no accept in that same cycle.
REQ-026 out_valid SHALL be 0 in all states except DONE.

Reset
REQ-027 rst = 1 at an edge SHALL force IDLE, in_ready = 1, out_valid = 0, result = 0, flags = 0, accumulator and counter cleared.
REQ-028 rst during MUL, NORM, ROUND or DONE SHALL abandon the operation; no result emitted for it.
REQ-029 rst has priority over in_valid and out_ready in the same cycle.

Structure
REQ-030 Shared package fp32_pkg SHALL hold field widths (EXP_W = 8, FRAC_W = 23), EXP_BIAS = 127, QNAN = 0x7FC00000, POS_INF = 0x7F800000, and the FSM state enum.
REQ-031 One sub-module fp_mant_mul_iter SHALL implement the iterative significand multiplier (start, done, 24-bit operands, 48-bit product), used by the Divide-companion flow and this block.
REQ-032 Unpack, special-case decode, normalise and round SHALL be in fp_multiply itself.

Verification
REQ-033 a = 0x3FA00000 (1.25), b = 0x3F400000 (0.75) -> result 0x3F700000, flags 000, out_valid at cycle 27.
REQ-034 a = 0x411C0000 (9.75), b = 0xBF100000 (-0.5625) -> result 0xC0AF8000, flags 000.
REQ-035 a = 0x7F000000, b = 0x40000000 -> result 0x7F800000, overflow = 1; a = 0x00800000, b = 0x00800000 -> 0x00000000, underflow = 1.
REQ-036 a = 0x7F800000, b = 0x80000000 -> 0x7FC00000, invalid = 1, out_valid at cycle 1; a = 0x3F800001, b = 0x3F800001 -> 0x3F800002.
REQ-037 out_ready held 0 for 10 cycles in DONE -> result and flags stable and in_ready = 0 throughout; one-cycle out_ready -> IDLE next cycle.
REQ-038 rst asserted in MUL cycle 10 -> IDLE next cycle, no out_valid; next operation completes correctly.
